// File: rtl/hot_bit_serializer.sv
// Walks a set-bit mask and streams the index of each set bit, lowest first,
// one index per accepted output beat over a valid/ready handshake.
module hot_bit_serializer #(
    parameter  int unsigned Depth = 8,
    localparam int unsigned Bits  = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Depth-1:0] in_mask_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Bits-1:0]  out_index_o,
    output logic             out_last_o,
    output logic             zero_drop_o,
    output logic             busy_o
);

    typedef enum logic [0:0] {StIdle, StEmit} state_e;

    state_e           state_q;
    logic [Depth-1:0] pending_q;
    logic             zero_drop_q;

    logic [Depth-1:0] pending_rest;
    logic [Bits-1:0]  low_index;
    logic             single_bit;
    logic             emitting;

    // Clearing the lowest set bit is the same as clearing pending[low_index].
    assign pending_rest = pending_q & (pending_q - Depth'(1));
    assign single_bit   = (pending_rest == '0);
    assign emitting     = (state_q == StEmit);

    always_comb begin
        low_index = '0;
        for (int i = Depth - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                low_index = Bits'(i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            pending_q   <= '0;
            zero_drop_q <= 1'b0;
        end else begin
            zero_drop_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // in_mask is only looked at under in_valid so X cannot leak.
                    if (in_valid_i) begin
                        if (|in_mask_i) begin
                            pending_q <= in_mask_i;
                            state_q   <= StEmit;
                        end else begin
                            zero_drop_q <= 1'b1;
                        end
                    end
                end
                StEmit: begin
                    if (out_ready_i) begin
                        pending_q <= pending_rest;
                        if (single_bit) begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    pending_q <= '0;
                end
            endcase
        end
    end

    assign in_ready_o  = ~emitting;
    assign out_valid_o = emitting;
    assign busy_o      = emitting;
    assign out_index_o = emitting ? low_index : '0;
    assign out_last_o  = emitting & single_bit;
    assign zero_drop_o = zero_drop_q;

endmodule

// File: tb/tb_hot_bit_serializer.sv
// Directed checks of hot_bit_serializer at Depth=8 and Depth=32.
module tb_hot_bit_serializer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_zero_drop, a_busy;
    logic [7:0] a_in_mask;
    logic [2:0] a_out_index;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_zero_drop, b_busy;
    logic [31:0] b_in_mask;
    logic [4:0]  b_out_index;

    int checks = 0;
    int errors = 0;
    int busy_cnt;

    hot_bit_serializer #(.Depth(8)) u_dut8 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (a_in_valid),
        .in_ready_o (a_in_ready),
        .in_mask_i  (a_in_mask),
        .out_valid_o(a_out_valid),
        .out_ready_i(a_out_ready),
        .out_index_o(a_out_index),
        .out_last_o (a_out_last),
        .zero_drop_o(a_zero_drop),
        .busy_o     (a_busy)
    );

    hot_bit_serializer #(.Depth(32)) u_dut32 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (b_in_valid),
        .in_ready_o (b_in_ready),
        .in_mask_i  (b_in_mask),
        .out_valid_o(b_out_valid),
        .out_ready_i(b_out_ready),
        .out_index_o(b_out_index),
        .out_last_o (b_out_last),
        .zero_drop_o(b_zero_drop),
        .busy_o     (b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect an emitting beat on the Depth=8 instance.
    task automatic beat8(input string tag, input int idx, input bit last);
        chk({tag, ".valid"}, 32'(a_out_valid), 32'd1);
        chk({tag, ".index"}, 32'(a_out_index), 32'(idx));
        chk({tag, ".last"}, 32'(a_out_last), 32'(last));
        chk({tag, ".in_ready"}, 32'(a_in_ready), 32'd0);
    endtask

    task automatic idle8(input string tag);
        chk({tag, ".valid"}, 32'(a_out_valid), 32'd0);
        chk({tag, ".in_ready"}, 32'(a_in_ready), 32'd1);
        chk({tag, ".busy"}, 32'(a_busy), 32'd0);
        chk({tag, ".index"}, 32'(a_out_index), 32'd0);
        chk({tag, ".last"}, 32'(a_out_last), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_mask = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_mask = '0; b_out_ready = 1'b1;
        #12;
        idle8("reset");
        chk("reset.zero_drop", 32'(a_zero_drop), 32'd0);
        chk("reset32.valid", 32'(b_out_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: mask 1010_0100 with ready held high.
        a_in_valid = 1'b1; a_in_mask = 8'b1010_0100;
        tick();
        a_in_valid = 1'b0; a_in_mask = '0;
        beat8("t1.b0", 2, 1'b0);
        chk("t1.busy", 32'(a_busy), 32'd1);
        tick();
        beat8("t1.b1", 5, 1'b0);
        tick();
        beat8("t1.b2", 7, 1'b1);
        tick();
        idle8("t1.done");

        // 2: backpressure on first beat; in_mask offered during EMIT is ignored.
        a_in_valid = 1'b1; a_in_mask = 8'b1010_0100;
        tick();
        a_in_mask = 8'hFF;
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            beat8("t2.hold", 2, 1'b0);
            tick();
        end
        a_in_valid = 1'b0; a_in_mask = '0;
        a_out_ready = 1'b1;
        beat8("t2.b0", 2, 1'b0);
        tick();
        beat8("t2.b1", 5, 1'b0);
        tick();
        beat8("t2.b2", 7, 1'b1);
        tick();
        idle8("t2.done");

        // 3: all-zero mask is dropped with a one-cycle pulse.
        a_in_valid = 1'b1; a_in_mask = 8'h00;
        tick();
        a_in_valid = 1'b0;
        chk("t3.zero_drop", 32'(a_zero_drop), 32'd1);
        idle8("t3.drop");
        tick();
        chk("t3.zero_drop_end", 32'(a_zero_drop), 32'd0);
        idle8("t3.after");

        // X on in_mask with in_valid low must stay invisible.
        a_in_mask = 'x;
        tick();
        tick();
        idle8("tx");
        chk("tx.zero_drop", 32'(a_zero_drop), 32'd0);

        // 4: full mask.
        a_in_valid = 1'b1; a_in_mask = 8'hFF;
        tick();
        a_in_valid = 1'b0; a_in_mask = '0;
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (a_busy) busy_cnt++;
            beat8("t4.beat", i, i == 7);
            tick();
        end
        if (a_busy) busy_cnt++;
        chk("t4.busy_cycles", 32'(busy_cnt), 32'd8);
        idle8("t4.done");

        // 5: reset while emitting 1111_0000 after index 5 is taken.
        a_in_valid = 1'b1; a_in_mask = 8'b1111_0000;
        tick();
        a_in_valid = 1'b0; a_in_mask = '0;
        beat8("t5.b0", 4, 1'b0);
        tick();
        beat8("t5.b1", 5, 1'b0);
        tick();
        beat8("t5.b2", 6, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        idle8("t5.async");
        tick();
        rst_n = 1'b1;
        tick();
        idle8("t5.release");
        tick();
        idle8("t5.nostale");

        // 6: Depth=32 back-to-back masks with in_valid held high.
        b_in_valid = 1'b1; b_in_mask = 32'h8000_0001;
        tick();
        b_in_mask = 32'h8000_0000;
        chk("t6.b0.valid", 32'(b_out_valid), 32'd1);
        chk("t6.b0.index", 32'(b_out_index), 32'd0);
        chk("t6.b0.last", 32'(b_out_last), 32'd0);
        tick();
        chk("t6.b1.index", 32'(b_out_index), 32'd31);
        chk("t6.b1.last", 32'(b_out_last), 32'd1);
        chk("t6.b1.in_ready", 32'(b_in_ready), 32'd0);
        tick();
        chk("t6.gap.valid", 32'(b_out_valid), 32'd0);
        chk("t6.gap.in_ready", 32'(b_in_ready), 32'd1);
        tick();
        b_in_valid = 1'b0; b_in_mask = '0;
        chk("t6.m2.valid", 32'(b_out_valid), 32'd1);
        chk("t6.m2.index", 32'(b_out_index), 32'd31);
        chk("t6.m2.last", 32'(b_out_last), 32'd1);
        tick();
        chk("t6.done.valid", 32'(b_out_valid), 32'd0);
        chk("t6.done.in_ready", 32'(b_in_ready), 32'd1);
        chk("t6.zero_drop", 32'(b_zero_drop), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
